// File: rtl/uart_fifo_tx.sv
// rtl/uart_fifo_tx.sv - 8N1 UART transmitter draining a byte FIFO via one-cycle read requests
module uart_fifo_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       FE,
    input  logic [7:0] DI,
    output logic       RREQ,
    output logic       TX,
    output logic       BUSY
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, STOP} state_t;

    state_t        state, state_next;
    logic [CW-1:0] baud_cnt, baud_next;
    logic [2:0]    bit_cnt, bit_next;
    logic [7:0]    shift, shift_next;
    logic          tx_q, tx_next;
    logic          bit_end;

    assign bit_end = (baud_cnt == BAUD_LAST);

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        shift_next = shift;
        tx_next    = 1'b1;

        if (state == START || state == DATA || state == STOP) begin
            baud_next = bit_end ? '0 : baud_cnt + CW'(1);
        end

        case (state)
            IDLE:  if (EN && !FE) state_next = REQ;
            REQ:   state_next = LOAD;
            LOAD: begin
                shift_next = DI;
                baud_next  = '0;
                bit_next   = '0;
                state_next = START;
            end
            START: if (bit_end) state_next = DATA;
            DATA: begin
                if (bit_end) begin
                    shift_next = {1'b0, shift[7:1]};
                    bit_next   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_next = STOP;
                end
            end
            STOP:  if (bit_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // TX is registered from the line value of the state being entered
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            shift    <= shift_next;
            tx_q     <= tx_next;
        end
    end

    assign RREQ = (state == REQ);
    assign BUSY = (state != IDLE);
    assign TX   = tx_q;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// tb/tb_uart_fifo_tx.sv - self-checking bench for uart_fifo_tx with FIFO model and frame-level reference
module tb_uart_fifo_tx;

    localparam int CPB  = 4;
    localparam int MAXC = 16384;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       EN  = 1'b0;
    logic       FE;
    logic [7:0] DI  = 8'h00;
    logic       RREQ, TX, BUSY;
    bit         fe  = 1'b1;

    assign FE = fe;

    uart_fifo_tx #(.CLKS_PER_BIT(CPB)) dut (
        .CLK (CLK),
        .RST (RST),
        .EN  (EN),
        .FE  (FE),
        .DI  (DI),
        .RREQ(RREQ),
        .TX  (TX),
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    logic [7:0] q[$];
    int  rreq_count = 0;
    bit  model_ok   = 1'b0;
    bit  exp_busy [MAXC];
    bit  exp_tx   [MAXC];
    bit  rst_h    [MAXC];
    bit  en_h     [MAXC];
    bit  fe_h     [MAXC];

    // FIFO model plus per-cycle frame reference: a read starts a 42-cycle busy window
    // whose TX bits are the 8N1 frame of the popped byte, each CPB cycles wide.
    always @(negedge CLK) begin
        int         c;
        bit         erq;
        logic [7:0] b;
        logic [9:0] fr;
        c   = cyc;
        erq = 1'b0;
        if (c >= 1 && c < MAXC - 64) begin
            if (rst_h[c-1]) begin
                model_ok = 1'b1;
                for (int i = 0; i < 48; i++) begin
                    exp_busy[c+i] = 1'b0;
                    exp_tx[c+i]   = 1'b1;
                end
            end else if (model_ok && !exp_busy[c-1] && en_h[c-1] && !fe_h[c-1]) begin
                erq = 1'b1;
                b   = (q.size() > 0) ? q[0] : 8'h00;
                fr  = {1'b1, b, 1'b0};
                for (int i = 0; i < 10 * CPB + 2; i++) exp_busy[c+i] = 1'b1;
                for (int i = 0; i < 10 * CPB; i++) exp_tx[c+2+i] = fr[i/CPB];
            end
            if (model_ok) begin
                check("rreq", {31'd0, RREQ}, {31'd0, erq});
                check("tx", {31'd0, TX}, {31'd0, exp_tx[c]});
                check("busy", {31'd0, BUSY}, {31'd0, exp_busy[c]});
            end
            rst_h[c] = RST;
            en_h[c]  = EN;
        end
        if (RREQ === 1'b1) begin
            rreq_count++;
            if (q.size() > 0) DI = q.pop_front();
        end
        fe = (q.size() == 0);
        if (c < MAXC) fe_h[c] = fe;
    end

    task automatic push(input logic [7:0] b);
        q.push_back(b);
    endtask

    task automatic wait_rreq(output int r);
        int n;
        n = 0;
        @(negedge CLK);
        while (RREQ !== 1'b1 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        check("rreq_arrives", {31'd0, RREQ}, 32'd1);
        r = cyc;
    endtask

    // Samples TX mid-bit for all ten bits of the frame started by the next RREQ
    task automatic capture(output logic [9:0] fr, output int r);
        fr = '0;
        wait_rreq(r);
        repeat (3) @(negedge CLK);
        fr[0] = TX;
        for (int k = 1; k < 10; k++) begin
            repeat (CPB) @(negedge CLK);
            fr[k] = TX;
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [9:0] fr;
        int r, r_prev, base, e, n, highs;

        for (int i = 0; i < MAXC; i++) exp_tx[i] = 1'b1;
        vecs[0] = '{8'hA5, 10'h34A};
        vecs[1] = '{8'h00, 10'h200};
        vecs[2] = '{8'hFF, 10'h3FE};
        vecs[3] = '{8'h3C, 10'h278};
        vecs[4] = '{8'h81, 10'h302};

        // reset with arbitrary enable
        EN  = 1'($urandom_range(0, 1));
        RST = 1'b1;
        @(negedge CLK);
        check("reset_tx", {31'd0, TX}, 32'd1);
        check("reset_rreq", {31'd0, RREQ}, 32'd0);
        check("reset_busy", {31'd0, BUSY}, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        EN  = 1'b1;
        repeat (3) @(negedge CLK);

        // single bytes from the vector table
        foreach (vecs[v]) begin
            @(posedge CLK); #1;
            base = rreq_count;
            push(vecs[v].data);
            capture(fr, r);
            check("frame", {22'd0, fr}, {22'd0, vecs[v].frame});
            repeat (2) @(negedge CLK);
            check("busy_last", {31'd0, BUSY}, 32'd1);
            @(negedge CLK);
            check("busy_drop", {31'd0, BUSY}, 32'd0);
            repeat (5) @(negedge CLK);
            check("single_pulse", rreq_count - base, 32'd1);
        end

        // back-to-back 0x00, 0xFF, 0x55
        @(posedge CLK); #1;
        base = rreq_count;
        push(8'h00); push(8'hFF); push(8'h55);
        capture(fr, r);
        check("b2b_frame0", {22'd0, fr}, 32'h200);
        r_prev = r;
        capture(fr, r);
        check("b2b_frame1", {22'd0, fr}, 32'h3FE);
        check("b2b_gap1", r - r_prev, 10 * CPB + 3);
        r_prev = r;
        capture(fr, r);
        check("b2b_frame2", {22'd0, fr}, 32'h2AA);
        check("b2b_gap2", r - r_prev, 10 * CPB + 3);
        repeat (60) @(negedge CLK);
        check("b2b_no_extra", rreq_count - base, 32'd3);

        // enable gating with two bytes queued
        @(posedge CLK); #1;
        base = rreq_count;
        push(8'h5A); push(8'hC3);
        wait_rreq(r);
        repeat (10) @(negedge CLK);
        @(posedge CLK); #1;
        EN = 1'b0;
        repeat (60) @(negedge CLK);
        check("gate_one_pulse", rreq_count - base, 32'd1);
        check("gate_idle_busy", {31'd0, BUSY}, 32'd0);
        check("gate_idle_tx", {31'd0, TX}, 32'd1);
        @(posedge CLK); #1;
        EN = 1'b1;
        e  = cyc;
        @(negedge CLK);
        check("gate_no_early", {31'd0, RREQ}, 32'd0);
        @(negedge CLK);
        check("gate_restart", {31'd0, RREQ}, 32'd1);
        check("gate_latency", cyc - e, 32'd1);
        repeat (50) @(negedge CLK);

        // empty FIFO
        base  = rreq_count;
        highs = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (TX === 1'b1) highs++;
        end
        check("empty_rreq", rreq_count - base, 32'd0);
        check("empty_tx_high", highs, 32'd100);

        // reset during data bit 3, next byte must go out intact
        @(posedge CLK); #1;
        push(8'h96); push(8'h3C);
        wait_rreq(r);
        repeat (18) @(negedge CLK);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(negedge CLK);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        check("rst_mid_tx", {31'd0, TX}, 32'd1);
        check("rst_mid_busy", {31'd0, BUSY}, 32'd0);
        capture(fr, r_prev);
        check("rst_next_frame", {22'd0, fr}, 32'h278);
        check("rst_next_start", r_prev - r, 32'd21);
        repeat (10) @(negedge CLK);

        // randomized traffic, enable toggling and occasional resets against the model
        for (int i = 0; i < 1500; i++) begin
            @(posedge CLK); #1;
            RST = 1'b0;
            if ($urandom_range(0, 29) == 0) push(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 99) == 0) EN = !EN;
            if ($urandom_range(0, 499) == 0) RST = 1'b1;
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        EN  = 1'b1;
        n = 0;
        while ((q.size() > 0 || BUSY !== 1'b0) && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        check("drain_done", {31'd0, (q.size() == 0 && BUSY === 1'b0)}, 32'd1);
        repeat (5) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_fifo_tx.md
# uart_fifo_tx

Serial UART transmitter that drains the 8-bit byte FIFO from its read side. Whenever the FIFO reports non-empty and transmission is enabled, it issues a one-cycle read request and captures the returned byte. It then shifts the byte out on `TX` as an 8N1 frame: start bit, 8 data bits LSB first, one stop bit. It sits between the CPU-side FIFO writer and the board's serial TX pin.

## Interface

- `CLKS_PER_BIT`, default 434 (50 MHz / 115200 baud): CLK cycles per serial bit; legal range ≥ 2.
- `CLK`  in  1  system clock; all logic on posedge.
- `RST`  in  1  synchronous, active-high reset.
- `EN`  in  1  transmit enable; gates only the start of new frames.
- `FE`  in  1  FIFO empty flag (combinational, from FIFO).
- `DI`  in  8  FIFO read data; registered by the FIFO on the CLK edge where `RREQ`=1.
- `RREQ`  out  1  FIFO read request; one-cycle pulse per byte.
- `TX`  out  1  serial line; idle high; registered.
- `BUSY`  out  1  high whenever state ≠ IDLE.

## Operation

- States: IDLE, REQ, LOAD, START, DATA, STOP.
- **IDLE**
  - `TX`=1.
  - If `EN`=1 and `FE`=0, go to REQ. Otherwise stay.
- **REQ**
  - `RREQ`=1, decoded combinationally from state, for exactly this one cycle.
  - Always go to LOAD.
- **LOAD**
  - `DI` is valid. Capture it into the 8-bit shift register.
  - Clear the bit counter and baud counter. Go to START.
- **START**
  - `TX`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- **DATA**
  - `TX`=shift[0] for `CLKS_PER_BIT` cycles per bit.
  - At the end of each bit, shift right and increment the 3-bit bit counter.
  - After bit index 7, go to STOP.
- **STOP**
  - `TX`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- **Counters**
  - Baud counter width is $clog2(`CLKS_PER_BIT`). It counts 0..`CLKS_PER_BIT`-1 and wraps to 0.
  - The bit-end event is counter == `CLKS_PER_BIT`-1.
  - Bit counter wraps 7→0 on exit from DATA.
- **`TX` source**
  - `TX` is driven from a register loaded with the next-state line value.
  - Each bit is therefore exactly `CLKS_PER_BIT` cycles wide, with no glitches.
- **`EN` low**
  - Prevents IDLE→REQ only.
  - A frame already in REQ..STOP always completes.
- **`FE` sampling**
  - `FE` is sampled only in IDLE.
  - Changes of `FE` in any other state are ignored.
- **Stale data**: a read is never issued while `FE`=1, so stale FIFO data is never transmitted.
- **Reset**
  - Synchronous. On the first CLK edge with `RST`=1: state=IDLE, `TX`=1, `RREQ`=0, `BUSY`=0, counters=0, shift register=0.
  - Reset mid-frame aborts the frame; `TX` returns high at that edge.
  - The byte already popped is lost. The FIFO read pointer is not rewound.
  - If `RST` is high during REQ, `RREQ` is still high in that cycle, because it is decoded from the pre-edge state. The FIFO pops one byte that is then discarded. This is accepted behaviour.

## Timing

- **Start latency**: `FE` falls (with `EN`=1) in cycle t0, IDLE.
  - t0+1: REQ, `RREQ`=1.
  - t0+2: LOAD.
  - t0+3: START; `TX` falls at the edge ending LOAD.
- **Frame length**: 10×`CLKS_PER_BIT` cycles of `TX` activity.
- **Back-to-back**:
  - STOP → IDLE → REQ → LOAD → START adds exactly 3 idle-high cycles between frames.
  - Total per-byte period is 10×`CLKS_PER_BIT`+3 cycles.
- **`RREQ`**: asserted 1 cycle per transmitted byte, never 2 consecutive cycles.
- **`BUSY`**: rises on entry to REQ and falls on entry to IDLE.

## Test plan

- **Reset values**: hold `RST` 2 cycles with arbitrary inputs → `TX`=1, `RREQ`=0, `BUSY`=0 after the first edge.
- **Single byte**, `CLKS_PER_BIT`=4: FIFO holds 0xA5, `EN`=1.
  - Exactly one `RREQ` pulse.
  - `TX` sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1 (start, LSB-first 0xA5, stop).
  - `BUSY` low again after 40+2 cycles from REQ.
- **Back-to-back**: FIFO holds 0x00, 0xFF, 0x55.
  - Three `RREQ` pulses spaced 43 cycles apart.
  - Decoded bytes on `TX` are 0x00, 0xFF, 0x55.
  - No extra pulse once `FE`=1.
- **Enable gating**: drop `EN` mid-DATA of byte 1 with 2 bytes queued.
  - Byte 1 completes.
  - No `RREQ` until `EN` is restored.
  - Byte 2 starts 1 cycle after `EN`=1 is seen in IDLE.
- **Empty FIFO**: `FE`=1 for 100 cycles → `RREQ` never asserted, `TX` constant 1.
- **Reset mid-frame**: assert `RST` during DATA bit 3 → `TX`=1 at the next edge, state IDLE.
  - The next queued byte is transmitted intact after `RST` is released.
